// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned NB = WIDTH / 8;

    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [NB-1:0]    mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per core request, with byte
// enables, store-lane replication, load extension, illegal-size and timeout
// errors. Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module lsu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_lsu_valid,
    input  logic             i_lsu_we,
    input  logic [2:0]       i_lsu_funct3,
    input  logic [WIDTH-1:0] i_lsu_addr,
    input  logic [WIDTH-1:0] i_lsu_wdata,
    output logic [WIDTH-1:0] o_lsu_rdata,
    output logic             o_lsu_done,
    output logic             o_lsu_err,
    output logic             o_lsu_busy,
    lsu_if.master            mem_bus
);
    localparam int unsigned NB = 4;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [CW-1:0]    r_cnt;
    logic             r_req, r_we, r_done, r_err, r_busy;
    logic [WIDTH-1:0] r_addr, r_wdata, r_rdata;
    logic [NB-1:0]    r_be;

    logic             w_illegal, w_misalign;
    logic             w_start, w_fin_ok, w_fin_err, w_cnt_inc;
    logic [NB-1:0]    w_be;
    logic [WIDTH-1:0] w_st_data, w_ld_data;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    assign o_lsu_rdata       = r_rdata;
    assign o_lsu_done        = r_done;
    assign o_lsu_err         = r_err;
    assign o_lsu_busy        = r_busy;
    assign mem_bus.mem_req   = r_req;
    assign mem_bus.mem_we    = r_we;
    assign mem_bus.mem_addr  = r_addr;
    assign mem_bus.mem_be    = r_be;
    assign mem_bus.mem_wdata = r_wdata;

    // Request decode: legality, alignment, byte enables and replicated store data.
    always_comb begin
        w_illegal  = 1'b1;
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_st_data  = i_lsu_wdata;
        case (i_lsu_funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = i_lsu_we;
            default:                w_illegal = 1'b1;
        endcase
`ifdef MISALIGN_TRAP_EN
        w_misalign = ((i_lsu_funct3[1:0] == 2'b01) && i_lsu_addr[0]) ||
                     ((i_lsu_funct3[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        case (i_lsu_funct3[1:0])
            2'b00: begin
                w_be      = 4'b0001 << i_lsu_addr[1:0];
                w_st_data = {4{i_lsu_wdata[7:0]}};
            end
            2'b01: begin
                w_be      = 4'b0011 << {i_lsu_addr[1], 1'b0};
                w_st_data = {2{i_lsu_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_st_data = i_lsu_wdata;
            end
        endcase
    end

    // Load formatting: lane select by offset, then sign or zero extension.
    always_comb begin
        w_byte    = 8'(mem_bus.mem_rdata >> {r_off, 3'b000});
        w_half    = r_off[1] ? mem_bus.mem_rdata[31:16] : mem_bus.mem_rdata[15:0];
        w_ld_data = mem_bus.mem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_ld_data = r_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ld_data = r_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ld_data = mem_bus.mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; ready is checked before the timeout so success wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fin_ok    = 1'b0;
        w_fin_err   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_lsu_valid) begin
                    if (w_illegal || w_misalign) begin
                        w_state_nxt = S_DONE;
                        w_fin_err   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_start     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_bus.mem_ready) begin
                    w_state_nxt = S_DONE;
                    w_fin_ok    = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_DONE;
                    w_fin_err   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, captured request fields and the wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_cnt    <= '0;
        end else begin
            r_req  <= (w_state_nxt == S_WAIT);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            r_err  <= w_fin_err;
            if (w_start) begin
                r_we     <= i_lsu_we;
                r_addr   <= {i_lsu_addr[WIDTH-1:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= w_st_data;
                r_funct3 <= i_lsu_funct3;
                r_off    <= i_lsu_addr[1:0];
                r_cnt    <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_fin_ok)       r_rdata <= r_we ? '0 : w_ld_data;
            else if (w_fin_err) r_rdata <= '0;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_lsu_valid, i_lsu_we;
    logic [2:0]  i_lsu_funct3;
    logic [31:0] i_lsu_addr, i_lsu_wdata;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_done, o_lsu_err, o_lsu_busy;

    lsu_if #(.WIDTH(WIDTH)) u_bus ();

    lsu #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_we     (i_lsu_we),
        .i_lsu_funct3 (i_lsu_funct3),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wdata  (i_lsu_wdata),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_lsu_done   (o_lsu_done),
        .o_lsu_err    (o_lsu_err),
        .o_lsu_busy   (o_lsu_busy),
        .mem_bus      (u_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the last access, sampled at negedges.
    int          t_lat;
    logic        t_err, t_req_seen, t_req_at_done, t_done_after, t_mwe, t_busy1;
    logic [3:0]  t_be;
    logic [31:0] t_rdata, t_rdata_after, t_maddr, t_mwdata;
    logic        seen_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access from a negedge; ready_at is the WAIT cycle with mem_ready high (0 = never).
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd, input int ready_at);
        t_lat = 0; t_err = 1'bx; t_rdata = 'x; t_req_seen = 1'b0; t_req_at_done = 1'bx;
        t_be = '0; t_maddr = '0; t_mwdata = '0; t_mwe = 1'b0; t_busy1 = 1'b0;
        i_lsu_valid = 1'b1; i_lsu_we = we; i_lsu_funct3 = f3;
        i_lsu_addr = addr; i_lsu_wdata = wdata;
        u_bus.mem_rdata = rd; u_bus.mem_ready = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            u_bus.mem_ready = (cyc == ready_at);
            if (cyc == 1) t_busy1 = o_lsu_busy;
            if (u_bus.mem_req && !t_req_seen) begin
                t_req_seen = 1'b1;
                t_be       = u_bus.mem_be;
                t_maddr    = u_bus.mem_addr;
                t_mwdata   = u_bus.mem_wdata;
                t_mwe      = u_bus.mem_we;
            end
            if (o_lsu_done) begin
                t_lat         = cyc;
                t_err         = o_lsu_err;
                t_rdata       = o_lsu_rdata;
                t_req_at_done = u_bus.mem_req;
                break;
            end
        end
        i_lsu_valid = 1'b0; u_bus.mem_ready = 1'b0;
        @(negedge clk);
        t_done_after  = o_lsu_done;
        t_rdata_after = o_lsu_rdata;
    endtask

    initial begin
        i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_lsu_funct3 = 3'b000;
        i_lsu_addr = '0; i_lsu_wdata = '0;
        u_bus.mem_rdata = '0; u_bus.mem_ready = 1'b0;
        seen_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdata", o_lsu_rdata, 32'h0);
        check("rst_flags", {28'h0, o_lsu_done, o_lsu_err, o_lsu_busy, u_bus.mem_req}, 32'h0);
        check("rst_mem", {27'h0, u_bus.mem_we, u_bus.mem_be}, 32'h0);
        check("rst_maddr", u_bus.mem_addr | u_bus.mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // SW, ready in first WAIT cycle
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        check("sw_busy1", t_busy1, 1);
        check("sw_addr", t_maddr, 32'h100);
        check("sw_be", 32'(t_be), 32'hF);
        check("sw_wdata", t_mwdata, 32'hDEADBEEF);
        check("sw_we", t_mwe, 1);
        check("sw_lat", t_lat, 2);
        check("sw_err", t_err, 0);
        check("sw_rdata", t_rdata, 32'h0);
        check("sw_pulse", t_done_after, 0);

        // LB / LBU at offset 3
        run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFF7F, 1);
        check("lb_be", 32'(t_be), 32'h8);
        check("lb_addr", t_maddr, 32'h200);
        check("lb_we", t_mwe, 0);
        check("lb_rdata", t_rdata, 32'hFFFFFF80);
        check("lb_hold", t_rdata_after, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFF7F, 3);
        check("lbu_rdata", t_rdata, 32'h00000080);
        check("lbu_lat", t_lat, 4);

        // SH / LHU / LH at offset 2, LH at offset 0
        run_op(1'b1, 3'b001, 32'h42, 32'h1234ABCD, 32'h0, 1);
        check("sh_be", 32'(t_be), 32'hC);
        check("sh_wdata", t_mwdata, 32'hABCDABCD);
        check("sh_addr", t_maddr, 32'h40);
        run_op(1'b0, 3'b101, 32'h42, 32'h0, 32'hBEEF0000, 1);
        check("lhu_rdata", t_rdata, 32'h0000BEEF);
        check("lhu_be", 32'(t_be), 32'hC);
        run_op(1'b0, 3'b001, 32'h42, 32'h0, 32'hBEEF0000, 2);
        check("lh_rdata", t_rdata, 32'hFFFFBEEF);
        run_op(1'b0, 3'b001, 32'h40, 32'h0, 32'h80007FFF, 1);
        check("lh0_rdata", t_rdata, 32'h00007FFF);
        check("lh0_be", 32'(t_be), 32'h3);

        // SB at offset 1
        run_op(1'b1, 3'b000, 32'h1, 32'h000000A5, 32'h0, 1);
        check("sb_be", 32'(t_be), 32'h2);
        check("sb_wdata", t_mwdata, 32'hA5A5A5A5);

        // LW with nonzero data, then timeout (ready never)
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1);
        check("lw_rdata", t_rdata, 32'hCAFEF00D);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 32'h11111111, 0);
        check("to_lat", t_lat, TIMEOUT + 1);
        check("to_err", t_err, 1);
        check("to_rdata", t_rdata, 32'h0);
        check("to_req_done", t_req_at_done, 0);
        check("to_req_seen", t_req_seen, 1);

        // Ready on the last allowed WAIT cycle
        run_op(1'b0, 3'b010, 32'h14, 32'h0, 32'h5A5A1234, TIMEOUT);
        check("to16_lat", t_lat, TIMEOUT + 1);
        check("to16_err", t_err, 0);
        check("to16_rdata", t_rdata, 32'h5A5A1234);

        // Illegal sizes: no bus access, done in cycle 1
        run_op(1'b0, 3'b011, 32'h20, 32'h0, 32'hFFFFFFFF, 1);
        check("ill_lat", t_lat, 1);
        check("ill_err", t_err, 1);
        check("ill_req", t_req_seen, 0);
        check("ill_rdata", t_rdata, 32'h0);
        run_op(1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 1);
        check("ill_sbu_err", t_err, 1);
        check("ill_sbu_req", t_req_seen, 0);

        // Misaligned LW
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h87654321, 1);
`ifdef MISALIGN_TRAP_EN
        check("mis_lat", t_lat, 1);
        check("mis_err", t_err, 1);
        check("mis_req", t_req_seen, 0);
`else
        check("mis_addr", t_maddr, 32'h100);
        check("mis_lat", t_lat, 2);
        check("mis_err", t_err, 0);
        check("mis_rdata", t_rdata, 32'h87654321);
`endif

        // Reset pulsed during WAIT
        i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_lsu_funct3 = 3'b010;
        i_lsu_addr = 32'h300; u_bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rstw_req_before", u_bus.mem_req, 1);
        rst = 1'b1;
        #1;
        check("rstw_req", u_bus.mem_req, 0);
        check("rstw_busy", o_lsu_busy, 0);
        check("rstw_maddr", u_bus.mem_addr, 32'h0);
        i_lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_done = seen_done | o_lsu_done;
        end
        check("rstw_nodone", seen_done, 0);
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 2);
        check("rstw_after_lat", t_lat, 3);
        check("rstw_after_addr", t_maddr, 32'h300);
        check("rstw_after_rdata", t_rdata, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
